ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
RV32M multiply/divide execute unit that sits directly downstream of the ID/EX pipeline register. It consumes the register operands and the decoded funct3 presented by ID/EX. MUL-family ops complete after a fixed short latency; DIV/REM run on an iterative radix-2 divider. While an op is in flight it holds the front of the pipeline with a stall output, then presents a one-cycle result to the EX/MEM boundary.

Parameters:
WIDTH, 32, operand/result width (only 32 supported; used for counter sizing and assertions)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous active-high reset
start  input  1  ID/EX holds a valid M-extension op (opcode op, funct7 = 7'b0000001); level, held high while stalled
flush  input  1  kill in-flight op (branch mispredict/trap), synchronous
funct3  input  3  muldiv_funct3_t: selects MUL..REMU
rs1_val  input  32  operand A (post-forwarding)
rs2_val  input  32  operand B (post-forwarding)
stall  output  1  freeze PC, IF/ID, ID/EX; combinational = start && !done && !flush
done  output  1  result valid this cycle (one-cycle pulse)
result  output  32  result, valid when done; holds last value otherwise
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE, done 0, result 0, busy 0, reuse cache invalid (when enabled); counter 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE: start && !flush latches funct3/operands. funct3[2]=0 -> MUL. funct3[2]=1 -> DIV, or directly DONE for the special cases below.
- MUL: one cycle. The registered 64-bit product is formed from sign-extended operands, with signedness per op: MULH s*s, MULHSU s*u, MULHU u*u. Then -> DONE.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- DIV: the signed op converts operands to magnitudes on accept. The counter loads 31 and runs 32 restoring shift-subtract iterations, one per cycle. Counter == 0 -> DONE.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - Sign fix-up is applied on the DIV->DONE edge.
- Special cases resolved in IDLE, going straight to DONE with no iterations:
  - B == 0: quotient 0xFFFFFFFF; remainder = A (signed and unsigned).
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- DONE: done = 1 and result is driven. The unit then always returns to IDLE and does not accept start in the same cycle.
- Pipeline advance and back-to-back ops:
  - stall is low in DONE, so ID/EX advances on the DONE->IDLE edge.
  - The next op is accepted the following cycle.
- Latency from the accept cycle (IDLE with start): done in cycle +2 for MUL-family, +33 for DIV/REM, +1 for special cases.
- Flush: in any state -> IDLE next edge. done is forced 0 that cycle, stall = 0, result unchanged, cache not updated.
  - Flush in DONE suppresses done.
- Reset mid-operation behaves as flush and also clears result and the cache.
- start deasserted mid-op (should not occur) does not abort; only flush/rst abort.
- Operands are sampled only at accept; rs1_val/rs2_val changes afterwards are ignored.

Optional Feature:
MULDIV_REM_REUSE_EN
- Defined:
  - A completed DIV/REM stores {A, B, signedness, quotient, remainder} in a valid cache.
  - A subsequent DIV<->REM partner op with the same signedness and identical operands goes IDLE->DONE directly (latency +1), returning the stored value.
  - A MUL-family op does not invalidate the cache; flush and rst do.
- Undefined: no cache registers; every DIV/REM takes the full latency.

Decomposition:
- rv32i_types package gains:
  - muldiv_funct3_t enum: mul=0, mulh=1, mulhsu=2, mulhu=3, div=4, divu=5, rem=6, remu=7
  - constant funct7_muldiv = 7'b0000001
  - muldiv_state_t enum for the four states
- One sub-module: radix2_divider (unsigned magnitudes in, quotient/remainder out, counter and iteration datapath), instantiated once.
- Sign handling, special cases, MUL, the FSM and the cache stay in ex_muldiv_unit.

Test Plan:
- MUL: 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB. done in cycle +2; stall high exactly 2 cycles.
- MULH: 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 (0xFFFFFFF9) / 2 -> 0xFFFFFFFD at cycle +33. REM of the same -> 0xFFFFFFFF. DIVU 100/7 -> 14, REMU -> 2.
- Divide-by-zero: DIVU 0x1234/0 -> 0xFFFFFFFF, REM 0x1234/0 -> 0x1234, both at +1. Overflow: DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
- Flush at iteration 10 of a DIV -> no done, stall low next cycle, busy 0. A following MUL 3x4 -> 12 with normal latency. Reset mid-DIV -> result 0.
- With MULDIV_REM_REUSE_EN: DIV 100/7 then REM 100/7 -> 2 at +1. REMU 100/7 after signed DIV -> full 33-cycle latency.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 type definitions for the M-extension execute unit:
// funct3 encodings, funct7 marker and muldiv FSM states.
package rv32i_types;

  localparam logic [6:0] funct7_muldiv = 7'b0000001;

  typedef enum logic [2:0] {
    mul    = 3'd0,
    mulh   = 3'd1,
    mulhsu = 3'd2,
    mulhu  = 3'd3,
    div    = 3'd4,
    divu   = 3'd5,
    rem    = 3'd6,
    remu   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/radix2_divider.sv
// Iterative restoring radix-2 divider on unsigned magnitudes.
// Ports: clk, rst, load (take operands), step (one iteration),
// dividend, divisor in; quotient/remainder are the values after
// the current step; last is high while the final step runs.
module radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;
  logic             ge;

  // Partial remainder gets the next dividend bit shifted in.
  assign shifted = {rem_q, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs};
  // When ge holds the true difference is below 2^WIDTH.
  assign sub     = shifted[WIDTH-1:0] - dvs;

  assign quotient  = {quo[WIDTH-2:0], ge};
  assign remainder = ge ? sub : shifted[WIDTH-1:0];
  assign last      = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      quo   <= '0;
      rem_q <= '0;
      dvs   <= '0;
    end else if (load) begin
      cnt   <= CW'(WIDTH - 1);
      quo   <= dividend;
      rem_q <= '0;
      dvs   <= divisor;
    end else if (step) begin
      quo   <= quotient;
      rem_q <= remainder;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execute unit behind ID/EX; stalls the front
// end while an op runs, then pulses done with the result for one cycle.
// Ports: clk, rst, start, flush, funct3, rs1_val, rs2_val in;
// stall, done, result, busy out.
// Optional macro MULDIV_REM_REUSE_EN: cache the last DIV/REM pair so
// the partner op with identical operands completes in one cycle.
module ex_muldiv_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t  state;
  muldiv_state_t  state_next;
  muldiv_funct3_t op;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             neg_q;
  logic             neg_r;

  logic is_div_in;
  logic sgn_in;
  logic is_rem_in;
  logic accept;
  logic b_zero;
  logic ovf;
  logic special;
  logic hit;

  logic [WIDTH-1:0] spec_val;
  logic [WIDTH-1:0] hit_val;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_div_in = funct3[2];
  assign sgn_in    = ~funct3[0];
  assign is_rem_in = funct3[1];
  assign accept    = (state == S_IDLE) && start && !flush;

  assign b_zero  = (rs2_val == '0);
  assign ovf     = sgn_in && (rs1_val == MIN_NEG) && (rs2_val == '1);
  assign special = b_zero || ovf;

  always_comb begin
    spec_val = '0;
    if (b_zero) spec_val = is_rem_in ? rs1_val : '1;
    else        spec_val = is_rem_in ? '0 : rs1_val;
  end

  assign a_mag = (sgn_in && rs1_val[WIDTH-1]) ? -rs1_val : rs1_val;
  assign b_mag = (sgn_in && rs2_val[WIDTH-1]) ? -rs2_val : rs2_val;

  logic             div_load;
  logic             div_step;
  logic             div_last;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dr;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] div_val;
  logic             div_fin;

  assign div_load = accept && is_div_in && !special && !hit;
  assign div_step = (state == S_DIV) && !flush;
  assign div_fin  = div_step && div_last;

  radix2_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (dq),
    .remainder (dr),
    .last      (div_last)
  );

  assign q_fix   = neg_q ? -dq : dq;
  assign r_fix   = neg_r ? -dr : dr;
  assign div_val = op[1] ? r_fix : q_fix;

  logic               sa;
  logic               sb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_val;

  // Wrapping product of sign/zero-extended operands gives the exact
  // 2*WIDTH-bit result for every signedness combination.
  assign sa   = (op != mulhu);
  assign sb   = (op == mulh) || (op == mul);
  assign prod = {{WIDTH{sa & opa[WIDTH-1]}}, opa}
              * {{WIDTH{sb & opb[WIDTH-1]}}, opb};
  assign mul_val = (op == mul) ? prod[WIDTH-1:0]
                               : prod[2*WIDTH-1:WIDTH];

`ifdef MULDIV_REM_REUSE_EN
  logic             c_valid;
  logic [WIDTH-1:0] c_a;
  logic [WIDTH-1:0] c_b;
  logic             c_sgn;
  logic             c_rem;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] c_r;

  // Only the partner op (DIV<->REM) of the cached one may reuse it.
  assign hit = c_valid && is_div_in
            && (rs1_val == c_a) && (rs2_val == c_b)
            && (sgn_in == c_sgn) && (is_rem_in != c_rem);
  assign hit_val = is_rem_in ? c_r : c_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      c_valid <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_sgn   <= 1'b0;
      c_rem   <= 1'b0;
      c_q     <= '0;
      c_r     <= '0;
    end else if (div_fin) begin
      c_valid <= 1'b1;
      c_a     <= opa;
      c_b     <= opb;
      c_sgn   <= ~op[0];
      c_rem   <= op[1];
      c_q     <= q_fix;
      c_r     <= r_fix;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (!is_div_in)          state_next = S_MUL;
          else if (special || hit) state_next = S_DONE;
          else                     state_next = S_DIV;
        end
      end
      S_MUL:  state_next = S_DONE;
      S_DIV:  if (div_last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= mul;
      opa    <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op    <= muldiv_funct3_t'(funct3);
      opa   <= rs1_val;
      opb   <= rs2_val;
      neg_q <= sgn_in && (rs1_val[WIDTH-1] ^ rs2_val[WIDTH-1]);
      neg_r <= sgn_in && rs1_val[WIDTH-1];
      if (is_div_in && special) result <= spec_val;
      else if (is_div_in && hit) result <= hit_val;
    end else if (!flush) begin
      if (state == S_MUL) result <= mul_val;
      else if (div_fin)   result <= div_val;
    end
  end

  assign done  = (state == S_DONE) && !flush;
  assign stall = start && !done && !flush;
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an
// arithmetic reference model of the RV32M rules.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  ex_muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .stall   (stall),
    .done    (done),
    .result  (result),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference cache state for the optional reuse feature.
  bit          m_cv = 0;
  logic [31:0] m_ca, m_cb;
  bit          m_cs, m_crem;

  task automatic model(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output int lat);
    longint x, y, p;
    int sa, sb;
    logic [31:0] q, rm;
    bit sgn, isrem, spec;
    sa = a;
    sb = b;
    if (f3 < 3'd4) begin
      x = (f3 == 3'd3) ? longint'({32'b0, a}) : longint'(sa);
      y = (f3 == 3'd0 || f3 == 3'd1) ? longint'(sb)
                                       : longint'({32'b0, b});
      p = x * y;
      r = (f3 == 3'd0) ? p[31:0] : p[63:32];
      lat = 2;
      return;
    end
    sgn = (f3 == 3'd4) || (f3 == 3'd6);
    isrem = (f3 == 3'd6) || (f3 == 3'd7);
    spec = 1;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      rm = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      rm = 0;
    end else begin
      spec = 0;
      if (sgn) begin
        q = sa / sb;
        rm = sa % sb;
      end else begin
        q = a / b;
        rm = a % b;
      end
    end
    r = isrem ? rm : q;
    lat = 33;
    if (spec) lat = 1;
`ifdef MULDIV_REM_REUSE_EN
    else if (m_cv && m_ca == a && m_cb == b && m_cs == sgn
             && m_crem != isrem) lat = 1;
    if (lat == 33) begin
      m_cv = 1;
      m_ca = a;
      m_cb = b;
      m_cs = sgn;
      m_crem = isrem;
    end
`endif
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] er;
    int el, k, nst;
    model(f3, a, b, er, el);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd0);
    start = 1;
    funct3 = f3;
    rs1_val = a;
    rs2_val = b;
    #1;
    nst = stall;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      nst += stall;
      rs1_val = $urandom;
      rs2_val = $urandom;
    end
    chk($sformatf("lat f3=%0d", f3), 32'(k), 32'(el));
    chk($sformatf("res f3=%0d %h %h", f3, a, b), result, er);
    chk("stall_cycles", 32'(nst), 32'(el));
    start = 0;
  endtask

  logic [31:0] la, lb;

  initial begin
    rst = 1;
    start = 0;
    flush = 0;
    funct3 = 0;
    rs1_val = 0;
    rs2_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'h1234, 32'd0);
    run_op(3'd6, 32'h1234, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd100, 32'd7);
    run_op(3'd6, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);

    // Flush partway through a divide.
    @(negedge clk);
    start = 1;
    funct3 = 3'd4;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1;
    #1;
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    flush = 0;
    start = 0;
    m_cv = 0;
    #1;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done2", {31'b0, done}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1;
    funct3 = 3'd5;
    rs1_val = 32'hDEAD_BEEF;
    rs2_val = 32'd5;
    repeat (7) @(negedge clk);
    rst = 1;
    start = 0;
    @(negedge clk);
    rst = 0;
    m_cv = 0;
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);

    la = 32'd1;
    lb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int sel;
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) b = $urandom_range(1, 20);
      else if (sel == 3) begin
        a = la;
        b = lb;
      end else if (sel == 4) b = -$urandom_range(1, 20);
      la = a;
      lb = b;
      run_op(3'($urandom_range(0, 7)), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
